// File: rtl/uart_rx_loader_pkg.sv
// Shared definitions for the serial program loader: default frame marker,
// frame FSM state encodings, UART bit-phase codes and small arithmetic helpers.
package uart_rx_loader_pkg;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;

  // UART bit-phase codes
  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_START = 2'd1;
  localparam logic [1:0] PH_DATA  = 2'd2;
  localparam logic [1:0] PH_STOP  = 2'd3;

  // Running 8-bit checksum accumulate (mod 256)
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // True when a word count exceeds the RAM depth of 2**addr_w words
  function automatic logic len_too_big(input logic [15:0] len, input int unsigned addr_w);
    return ({16'd0, len} > (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/uart_rx_loader_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver. Two-flop synchroniser, falling-edge
// start detection, mid-bit start re-check, centre sampling of data/stop bits.
// Emits a one-cycle valid or frame_err pulse per received byte.
module uart_rx_byte
  import uart_rx_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 278
) (
  input  logic       CLK,
  input  logic       I_RESET,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Bring the asynchronous line into the clock domain; keep previous level for edge detect
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit-phase sequencing: start re-check at half bit, then data/stop at bit centres
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (rx_prev_q && !rx_sync_q) begin
          phase_d = PH_START;
        end else begin
          phase_d = PH_IDLE;
        end
      end
      PH_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            phase_d = PH_IDLE;  // line went back high: glitch, no byte
          end else begin
            phase_d = PH_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            phase_d = PH_STOP;
          end else begin
            phase_d = PH_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          phase_d = PH_IDLE;  // re-arm immediately for the next start edge
          if (rx_sync_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Receiver state registers
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: serial program loader. Parses SYNC, LEN_HI, LEN_LO, then N
// 16-bit words (high byte first) and writes them to program RAM from address 0.
// Holds the core in reset during a load; releases it one cycle after DONE.
// Optional feature macro LOADER_CHECKSUM_EN: a trailing 8-bit sum of LEN_HI,
// LEN_LO and all data bytes must match, otherwise the frame is an error.
// Word counts up to 2**ADDR_W are supported; ADDR_W must not exceed 15.
module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 278,
  parameter int         ADDR_W       = 13,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              CLK,
  input  logic              I_RESET,
  input  logic              I_RX,
  output logic              O_RAM_WE,
  output logic [ADDR_W-1:0] O_RAM_ADDR,
  output logic [15:0]       O_RAM_DIN,
  output logic              O_CORE_RESET,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERROR
);

  localparam logic [ADDR_W:0]   REMAIN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [7:0]  rx_byte_s;
  logic        rx_valid_s, rx_ferr_s;
  logic [15:0] len_s;

  logic [2:0]        state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, core_q, core_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_din_q, ram_din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [7:0]        hi_q, hi_d, len_hi_q, len_hi_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK         (CLK),
    .I_RESET     (I_RESET),
    .rx_i        (I_RX),
    .byte_o      (rx_byte_s),
    .valid_o     (rx_valid_s),
    .frame_err_o (rx_ferr_s)
  );

  assign len_s = {len_hi_q, rx_byte_s};

  // Frame parser: consumes byte pulses, issues RAM writes, tracks status flags
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    we_d       = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    hi_d       = hi_q;
    len_hi_d   = len_hi_q;
    // Core is released the cycle after DONE is seen high
    if (done_q) begin
      core_d = 1'b0;
    end else begin
      core_d = core_q;
    end
`ifdef LOADER_CHECKSUM_EN
    if (rx_valid_s && (state_q != ST_IDLE)) begin
      csum_d = csum_add(csum_q, rx_byte_s);
    end else begin
      csum_d = csum_q;
    end
`endif
    if (rx_ferr_s && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end else if (rx_valid_s) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte_s == SYNC_BYTE) begin
            state_d = ST_LEN_HI;
            busy_d  = 1'b1;
            core_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = rx_byte_s;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (len_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else if (len_too_big(len_s, ADDR_W)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            remain_d = len_s[ADDR_W:0];
            state_d  = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_d    = rx_byte_s;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          we_d       = 1'b1;
          ram_addr_d = addr_q;
          ram_din_d  = {hi_q, rx_byte_s};
          remain_d   = remain_q - REMAIN_ONE;
          if (remain_q == REMAIN_ONE) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            addr_d  = addr_q + ADDR_ONE;  // last word leaves addr in range
            state_d = ST_DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (rx_byte_s == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Loader state and registered outputs
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_q     <= 1'b0;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= 16'd0;
      addr_q     <= '0;
      remain_q   <= '0;
      hi_q       <= 8'd0;
      len_hi_q   <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_q     <= core_d;
      we_q       <= we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      hi_q       <= hi_d;
      len_hi_q   <= len_hi_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign O_RAM_WE     = we_q;
  assign O_RAM_ADDR   = ram_addr_q;
  assign O_RAM_DIN    = ram_din_q;
  assign O_CORE_RESET = core_q;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_ERROR      = err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Bench for uart_rx_loader: drives framed byte streams on I_RX and checks RAM
// writes and status flags against a frame-level model of the loader.
module tb_uart_rx_loader;

  localparam int CPB = 16;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        I_RESET = 1'b1;
  logic        I_RX = 1'b1;
  logic        O_RAM_WE;
  logic [12:0] O_RAM_ADDR;
  logic [15:0] O_RAM_DIN;
  logic        O_CORE_RESET, O_BUSY, O_DONE, O_ERROR;

  int vectors = 0;
  int miscompares = 0;
  int wr_seen = 0;

  logic [7:0]  tx_q [$];
  logic [28:0] exp_q [$];
  bit m_done, m_err;
  int m_nwr, m_sync;
  logic done_prev = 1'b0;
  logic rise_prev = 1'b0;

  uart_rx_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(13)) dut (
    .CLK          (CLK),
    .I_RESET      (I_RESET),
    .I_RX         (I_RX),
    .O_RAM_WE     (O_RAM_WE),
    .O_RAM_ADDR   (O_RAM_ADDR),
    .O_RAM_DIN    (O_RAM_DIN),
    .O_CORE_RESET (O_CORE_RESET),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .O_ERROR      (O_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every write strobe against the predicted write list,
  // and the core-reset release timing around the rising edge of DONE
  always @(negedge CLK) begin
    if (!I_RESET) begin
      if (O_RAM_WE) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {3'b0, O_RAM_ADDR, O_RAM_DIN}, 32'hFFFF_FFFF);
        end else begin
          check("ram_write", {3'b0, O_RAM_ADDR, O_RAM_DIN}, {3'b0, exp_q.pop_front()});
        end
      end
      if (rise_prev) check("core_release", {31'd0, O_CORE_RESET}, 32'd0);
      if (O_DONE && !done_prev) check("core_held_at_done", {31'd0, O_CORE_RESET}, 32'd1);
      rise_prev <= O_DONE && !done_prev;
      done_prev <= O_DONE;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    I_RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int k = 0; k < 8; k++) begin
      I_RX = b[k];
      repeat (CPB) @(negedge CLK);
    end
    I_RX = stop_ok;
    repeat (CPB) @(negedge CLK);
    I_RX = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  // Frame-level model: scan the byte list for the first SYNC, read the length,
  // list the words it implies and decide success or abort.
  task automatic predict(input int bad_idx);
    int s, limit, n, idx;
    logic [7:0] sum;
    exp_q.delete();
    m_done = 1'b0; m_err = 1'b0; m_nwr = 0; s = -1;
    for (int i = 0; i < tx_q.size(); i++)
      if (s < 0 && i != bad_idx && tx_q[i] == SYNC) s = i;
    m_sync = s;
    limit = (bad_idx > s) ? bad_idx : tx_q.size();
    if (s + 2 >= limit) begin m_err = 1'b1; return; end
    n = int'({tx_q[s+1], tx_q[s+2]});
    sum = tx_q[s+1] + tx_q[s+2];
    if (n > 8192) begin m_err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      idx = s + 3 + 2 * w;
      if (idx + 1 >= limit) begin m_err = 1'b1; return; end
      exp_q.push_back({13'(w), tx_q[idx], tx_q[idx+1]});
      m_nwr++;
      sum = sum + tx_q[idx] + tx_q[idx+1];
    end
    if (CSUM_EN) begin
      idx = s + 3 + 2 * n;
      if (idx >= limit) m_err = 1'b1;
      else if (tx_q[idx] == sum) m_done = 1'b1;
      else m_err = 1'b1;
    end else begin
      m_done = 1'b1;
    end
  endtask

  task automatic run_test(input string name, input int bad_idx, input bit add_csum,
                          input bit x_done, input bit x_err, input int x_nwr,
                          input logic [15:0] x_last);
    int s, w0;
    logic [7:0] sum;
    if (add_csum && CSUM_EN) begin
      s = -1; sum = 8'd0;
      for (int i = 0; i < tx_q.size(); i++) begin
        if (s >= 0) sum = sum + tx_q[i];
        if (s < 0 && tx_q[i] == SYNC) s = i;
      end
      tx_q.push_back(sum);
    end
    predict(bad_idx);
    // Pin the model against hand-computed outcomes
    check({name, "_model_done"}, {31'd0, m_done}, {31'd0, x_done});
    check({name, "_model_err"}, {31'd0, m_err}, {31'd0, x_err});
    check({name, "_model_nwr"}, m_nwr, x_nwr);
    if (m_nwr > 0) check({name, "_model_last"}, {16'd0, exp_q[exp_q.size()-1][15:0]}, {16'd0, x_last});
    w0 = wr_seen;
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], i != bad_idx);
      if (i == m_sync) begin
        check({name, "_busy_mid"}, {31'd0, O_BUSY}, 32'd1);
        check({name, "_core_mid"}, {31'd0, O_CORE_RESET}, 32'd1);
        check({name, "_done_mid"}, {31'd0, O_DONE}, 32'd0);
      end
    end
    repeat (8) @(negedge CLK);
    check({name, "_done"}, {31'd0, O_DONE}, {31'd0, m_done});
    check({name, "_error"}, {31'd0, O_ERROR}, {31'd0, m_err});
    check({name, "_busy"}, {31'd0, O_BUSY}, 32'd0);
    check({name, "_core_reset"}, {31'd0, O_CORE_RESET}, {31'd0, !m_done});
    check({name, "_writes"}, wr_seen - w0, m_nwr);
    check({name, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    I_RESET = 1'b1;
    I_RX = 1'b1;
    repeat (4) @(negedge CLK);
    I_RESET = 1'b0;
    @(negedge CLK);
    check("rst_we", {31'd0, O_RAM_WE}, 32'd0);
    check("rst_addr", {19'd0, O_RAM_ADDR}, 32'd0);
    check("rst_din", {16'd0, O_RAM_DIN}, 32'd0);
    check("rst_core", {31'd0, O_CORE_RESET}, 32'd0);
    check("rst_busy", {31'd0, O_BUSY}, 32'd0);
    check("rst_done", {31'd0, O_DONE}, 32'd0);
    check("rst_error", {31'd0, O_ERROR}, 32'd0);
    repeat (4) @(negedge CLK);

    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_test("t1_two_words", -1, 1'b1, 1'b1, 1'b0, 2, 16'hABCD);

    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    run_test("t2_zero_len", -1, 1'b1, 1'b1, 1'b0, 0, 16'h0000);

    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
    run_test("t3_bad_stop", 3, 1'b0, 1'b0, 1'b1, 0, 16'h0000);

    tx_q = '{8'hA5, 8'h20, 8'h01};
    run_test("t4_too_long", -1, 1'b0, 1'b0, 1'b1, 0, 16'h0000);

    // Quarter-bit low glitch on the idle line must not start a byte
    begin
      int w0;
      w0 = wr_seen;
      I_RX = 1'b0;
      repeat (CPB / 4) @(negedge CLK);
      I_RX = 1'b1;
      repeat (3 * CPB) @(negedge CLK);
      check("t5_glitch_busy", {31'd0, O_BUSY}, 32'd0);
      check("t5_glitch_writes", wr_seen - w0, 32'd0);
    end
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_test("t5_after_glitch", -1, 1'b1, 1'b1, 1'b0, 2, 16'hABCD);

    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
    run_test("t7_sync_as_data", -1, 1'b1, 1'b1, 1'b0, 1, 16'hA5A5);

`ifdef LOADER_CHECKSUM_EN
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'h00};
    run_test("t6_csum_ok", -1, 1'b0, 1'b1, 1'b0, 1, 16'hA55A);

    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'h01};
    run_test("t6_csum_bad", -1, 1'b0, 1'b0, 1'b1, 1, 16'hA55A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
